// File: rtl/operand_conditioner_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : operand_conditioner_fifo
//  Brief   : ALU operand-B conditioner (pass/sub/not/neg/zero/ones/abs) whose
//            results, carry-in and flags are queued in a DEPTH-entry FIFO.
//  Revision: 1.0  initial release
// ============================================================================
module operand_conditioner_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_b,
    output logic             out_cin,
    output logic             out_ovf,
    output logic             out_bad,
    output logic [CW-1:0]    count
);

    localparam int               AW        = $clog2(DEPTH);
    localparam int               EW        = WIDTH + 3;
    localparam logic [CW-1:0]    c_depth   = CW'(DEPTH);
    localparam logic [WIDTH-1:0] c_min_neg = {1'b1, {(WIDTH-1){1'b0}}};

    logic [EW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_neg;
    logic             w_cin;
    logic             w_ovf;
    logic             w_bad;
    logic             w_push;
    logic             w_pop;
    logic [EW-1:0]    w_head;

    assign w_neg = ~in_b + 1'b1;

    always_comb begin
        w_b   = in_b;
        w_cin = 1'b0;
        w_bad = 1'b0;
        case (in_mode)
            3'b000: w_b = in_b;
            3'b001: begin
                w_b   = ~in_b;
                w_cin = 1'b1;
            end
            3'b010: w_b = ~in_b;
            3'b011: w_b = w_neg;
            3'b100: w_b = '0;
            3'b101: w_b = '1;
            3'b110: w_b = in_b[WIDTH-1] ? w_neg : in_b;
            3'b111: w_bad = 1'b1;
            default: w_b = in_b;
        endcase
    end

    // Two's-complement negation of the most-negative value wraps back onto itself.
    assign w_ovf = ((in_mode == 3'b011) || (in_mode == 3'b110)) && (in_b == c_min_neg);

    assign in_ready  = (r_count != c_depth);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the output mux masks it whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {w_bad, w_ovf, w_cin, w_b};
        end
    end

    assign w_head    = r_mem[r_rptr];
    assign out_b     = out_valid ? w_head[WIDTH-1:0] : '0;
    assign out_cin   = out_valid & w_head[WIDTH];
    assign out_ovf   = out_valid & w_head[WIDTH+1];
    assign out_bad   = out_valid & w_head[WIDTH+2];

endmodule
`default_nettype wire

// File: tb/tb_operand_conditioner_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : tb_operand_conditioner_fifo
//  Brief   : Directed + randomized bench for operand_conditioner_fifo with a
//            queue-based reference model.
//  Revision: 1.0  initial release
// ============================================================================
module tb_operand_conditioner_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [7:0] b;
        logic       cin;
        logic       ovf;
        logic       bad;
    } item_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_b;
    logic             out_cin;
    logic             out_ovf;
    logic             out_bad;
    logic [CW-1:0]    count;

    item_t model_q[$];
    int    n_checks;
    int    n_pass;
    int    n_fail;

    operand_conditioner_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_b      (in_b),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_b     (out_b),
        .out_cin   (out_cin),
        .out_ovf   (out_ovf),
        .out_bad   (out_bad),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic item_t model_xform(input logic [7:0] b, input logic [2:0] m);
        item_t r;
        int    ib;
        int    neg;
        ib  = int'(b);
        neg = (256 - ib) % 256;
        r   = '0;
        case (m)
            3'd0: r.b = b;
            3'd1: begin r.b = 8'(255 - ib); r.cin = 1'b1; end
            3'd2: r.b = 8'(255 - ib);
            3'd3: r.b = 8'(neg);
            3'd4: r.b = 8'd0;
            3'd5: r.b = 8'd255;
            3'd6: r.b = (ib >= 128) ? 8'(neg) : b;
            default: begin r.b = b; r.bad = 1'b1; end
        endcase
        r.ovf = ((m == 3'd3) || (m == 3'd6)) && (ib == 128);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string where);
        item_t h;
        logic  e;
        e = (model_q.size() == 0);
        h = e ? item_t'('0) : model_q[0];
        chk({where, ".count"},     32'(count),     32'(model_q.size()));
        chk({where, ".in_ready"},  32'(in_ready),  32'(model_q.size() != DEPTH));
        chk({where, ".out_valid"}, 32'(out_valid), 32'(!e));
        chk({where, ".out_b"},     32'(out_b),     32'(h.b));
        chk({where, ".out_cin"},   32'(out_cin),   32'(h.cin));
        chk({where, ".out_ovf"},   32'(out_ovf),   32'(h.ovf));
        chk({where, ".out_bad"},   32'(out_bad),   32'(h.bad));
    endtask

    // One clock: apply inputs, advance the model with what the edge should do, then check.
    task automatic cycle(input string where, input logic v, input logic [7:0] b,
                         input logic [2:0] m, input logic ordy);
        logic do_push;
        logic do_pop;
        in_valid  = v;
        in_b      = b;
        in_mode   = m;
        out_ready = ordy;
        do_push   = v && (model_q.size() != DEPTH);
        do_pop    = ordy && (model_q.size() != 0);
        @(posedge clk);
        #1;
        if (rst) begin
            model_q.delete();
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(model_xform(b, m));
        end
        check_outputs(where);
    endtask

    logic [7:0] sweep_b   [8];
    logic       sweep_cin [8];
    logic [7:0] edge_b    [4];
    logic [2:0] edge_m    [4];
    logic [7:0] edge_exp  [4];
    logic       edge_ovf  [4];

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        n_fail    = 0;
        in_valid  = 1'b0;
        in_b      = '0;
        in_mode   = '0;
        out_ready = 1'b0;
        sweep_b   = '{8'h35, 8'hCA, 8'hCA, 8'hCB, 8'h00, 8'hFF, 8'h35, 8'h35};
        sweep_cin = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        edge_b    = '{8'h80, 8'h80, 8'hFB, 8'h00};
        edge_m    = '{3'b011, 3'b110, 3'b110, 3'b011};
        edge_exp  = '{8'h80, 8'h80, 8'h05, 8'h00};
        edge_ovf  = '{1'b1, 1'b1, 1'b0, 1'b0};

        // Reset with in_valid held high: nothing may be enqueued.
        rst = 1'b1;
        cycle("rst0", 1'b1, 8'h55, 3'b000, 1'b0);
        cycle("rst1", 1'b1, 8'h55, 3'b000, 1'b0);
        rst = 1'b0;
        cycle("idle", 1'b0, 8'hAA, 3'b001, 1'b1);

        // Mode sweep on 0x35, consumer always ready; each item is head right after its push.
        for (int i = 0; i < 8; i++) begin
            cycle("sweep", 1'b1, 8'h35, 3'(i), 1'b1);
            chk("sweep.b_const",   32'(out_b),   32'(sweep_b[i]));
            chk("sweep.cin_const", 32'(out_cin), 32'(sweep_cin[i]));
            chk("sweep.bad_const", 32'(out_bad), 32'(i == 7));
        end
        cycle("sweep_drain", 1'b0, 8'h00, 3'b000, 1'b1);

        // Overflow corner values.
        for (int i = 0; i < 4; i++) begin
            cycle("edge", 1'b1, edge_b[i], edge_m[i], 1'b1);
            chk("edge.b_const",   32'(out_b),   32'(edge_exp[i]));
            chk("edge.ovf_const", 32'(out_ovf), 32'(edge_ovf[i]));
        end
        cycle("edge_drain", 1'b0, 8'h00, 3'b000, 1'b1);

        // Fill to full with consumer stalled; 0x05 held by producer until a slot frees.
        for (int i = 1; i <= 5; i++) begin
            cycle("fill", 1'b1, 8'(i), 3'b000, 1'b0);
        end
        chk("fill.full_not_ready", 32'(in_ready), 32'd0);
        cycle("fill_pop1", 1'b1, 8'h05, 3'b000, 1'b1);
        cycle("fill_push5", 1'b1, 8'h05, 3'b000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle("fill_drain", 1'b0, 8'h00, 3'b000, 1'b1);
        end
        chk("fill.empty_after_drain", 32'(count), 32'd0);

        // Streaming at occupancy 2 across pointer wrap.
        cycle("stream_pre0", 1'b1, 8'hA0, 3'b000, 1'b0);
        cycle("stream_pre1", 1'b1, 8'hA1, 3'b000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle("stream", 1'b1, 8'(8'hB0 + i), 3'b000, 1'b1);
            chk("stream.count_const", 32'(count), 32'd2);
        end
        for (int i = 0; i < 3; i++) begin
            cycle("stream_drain", 1'b0, 8'h00, 3'b000, 1'b1);
        end

        // Reset mid-stream, then a fresh push must come out cleanly.
        for (int i = 0; i < 3; i++) begin
            cycle("mid_fill", 1'b1, 8'(8'hC0 + i), 3'b010, 1'b0);
        end
        rst = 1'b1;
        cycle("mid_rst", 1'b1, 8'hEE, 3'b000, 1'b1);
        rst = 1'b0;
        chk("mid_rst.count_const", 32'(count), 32'd0);
        cycle("post_rst_push", 1'b1, 8'h7F, 3'b011, 1'b0);
        chk("post_rst.b_const", 32'(out_b), 32'h81);
        cycle("post_rst_pop", 1'b0, 8'h00, 3'b000, 1'b1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            cycle("rand", ($urandom_range(0, 3) != 0), 8'($urandom),
                  3'($urandom_range(0, 7)), ($urandom_range(0, 2) != 0));
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
